// File: rtl/thor2024_fpu_issue_if.sv
// Dispatch request and writeback handshake bundle for the Thor2024 FPU issue sequencer.
// The slave side is the sequencer; the master side is dispatch plus writeback.
interface thor2024_fpu_issue_if #(
  parameter int unsigned TAGW = 6,
  parameter int unsigned VW   = 64,
  parameter int unsigned IRW  = 41
);
  logic            req_valid;
  logic            req_ready;
  logic [IRW-1:0]  req_ir;
  logic [2:0]      req_rm;
  logic [VW-1:0]   req_a;
  logic [VW-1:0]   req_b;
  logic [VW-1:0]   req_c;
  logic [VW-1:0]   req_t;
  logic [VW-1:0]   req_p;
  logic [TAGW-1:0] req_tag;
  logic            wb_valid;
  logic            wb_ready;
  logic [TAGW-1:0] wb_tag;
  logic [VW-1:0]   wb_res;
  logic            wb_err;

  modport master (
    output req_valid, req_ir, req_rm, req_a, req_b, req_c, req_t, req_p, req_tag,
    input  req_ready,
    input  wb_valid, wb_tag, wb_res, wb_err,
    output wb_ready
  );

  modport slave (
    input  req_valid, req_ir, req_rm, req_a, req_b, req_c, req_t, req_p, req_tag,
    output req_ready,
    output wb_valid, wb_tag, wb_res, wb_err,
    input  wb_ready
  );
endinterface

// File: rtl/thor2024_fpu_issue.sv
// Thor2024 FPU issue sequencer: buffers FP ops, drives one at a time onto the FPU bus,
// forces an {a,b} change per op so the FPU restarts, blanks stale done, returns results.
module thor2024_fpu_issue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAGW    = 6,
  parameter int unsigned BLANK   = 3,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned VW      = 64,
  parameter int unsigned IRW     = 41
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  thor2024_fpu_issue_if.slave  bus,
  output logic [IRW-1:0]       fpu_ir,
  output logic [2:0]           fpu_rm,
  output logic [VW-1:0]        fpu_a,
  output logic [VW-1:0]        fpu_b,
  output logic [VW-1:0]        fpu_c,
  output logic [VW-1:0]        fpu_t,
  output logic [VW-1:0]        fpu_p,
  input  logic [VW-1:0]        fpu_o,
  input  logic                 fpu_done,
  output logic                 busy
);
  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_KICK = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;

  localparam logic [7:0] BLANK_LAST = 8'(BLANK - 1);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  typedef struct packed {
    logic [IRW-1:0]  ir;
    logic [2:0]      rm;
    logic [VW-1:0]   a;
    logic [VW-1:0]   b;
    logic [VW-1:0]   c;
    logic [VW-1:0]   t;
    logic [VW-1:0]   p;
    logic [TAGW-1:0] tag;
  } op_t;

  op_t           mem [DEPTH];
  op_t           op_q;
  op_t           head;
  op_t           req_op;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [2:0]    state;
  logic [7:0]    cnt;
  logic [VW-1:0] res_q;
  logic          err_q;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  assign req_op = '{bus.req_ir, bus.req_rm, bus.req_a, bus.req_b, bus.req_c,
                    bus.req_t, bus.req_p, bus.req_tag};
  assign head   = mem[rd_ptr[AW-1:0]];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign push  = bus.req_valid && !full && !flush;
  assign pop   = !flush && !empty &&
                 ((state == S_IDLE) || ((state == S_WB) && bus.wb_ready));

  assign bus.req_ready = rst_n && !full;
  assign bus.wb_valid  = (state == S_WB);
  assign bus.wb_tag    = op_q.tag;
  assign bus.wb_res    = res_q;
  assign bus.wb_err    = err_q;
  assign busy          = (state != S_IDLE) || !empty;

  // FPU bus: operands inverted for the kick cycle, predicate suppressed until real operands.
  assign fpu_ir = op_q.ir;
  assign fpu_rm = op_q.rm;
  assign fpu_a  = (state == S_KICK) ? ~op_q.a : op_q.a;
  assign fpu_b  = (state == S_KICK) ? ~op_q.b : op_q.b;
  assign fpu_c  = op_q.c;
  assign fpu_t  = op_q.t;
  assign fpu_p  = ((state == S_IDLE) || (state == S_KICK)) ? '0 : op_q.p;

  // FIFO storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= req_op;
  end

  // FIFO pointers with wrap bit; flush empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sequencer: the pop at the end overrides the case so IDLE and WB-exit share one launch path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_q  <= '0;
      cnt   <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_IDLE;
        S_KICK: begin
          state <= S_LOAD;
          cnt   <= '0;
        end
        S_LOAD: begin
          if (cnt == BLANK_LAST) begin
            state <= S_WAIT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_WAIT: begin
          if (fpu_done) begin
            res_q <= fpu_o;
            err_q <= 1'b0;
            state <= S_WB;
          end else if (cnt == TMO_LAST) begin
            res_q <= '0;
            err_q <= 1'b1;
            state <= S_WB;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_WB: begin
          if (bus.wb_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (pop) begin
        op_q <= head;
        cnt  <= '0;
        if (head.p[0]) begin
          state <= S_KICK;
        end else begin
          res_q <= head.t;
          err_q <= 1'b0;
          state <= S_WB;
        end
      end
    end
  end
endmodule

// File: tb/tb_thor2024_fpu_issue.sv
// Directed bench for the Thor2024 FPU issue sequencer with a behavioural change-detecting FPU.
module tb_thor2024_fpu_issue;
  localparam int unsigned TAGW = 6;
  localparam int unsigned VW   = 64;
  localparam int unsigned IRW  = 41;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [IRW-1:0] fpu_ir;
  logic [2:0]    fpu_rm;
  logic [VW-1:0] fpu_a, fpu_b, fpu_c, fpu_t, fpu_p, fpu_o;
  logic          fpu_done;
  logic          busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  thor2024_fpu_issue_if #(.TAGW(TAGW), .VW(VW), .IRW(IRW)) bus_if ();

  thor2024_fpu_issue #(
    .DEPTH(4), .TAGW(TAGW), .BLANK(3), .TIMEOUT(255), .VW(VW), .IRW(IRW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_if),
    .fpu_ir(fpu_ir), .fpu_rm(fpu_rm), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_c(fpu_c),
    .fpu_t(fpu_t), .fpu_p(fpu_p), .fpu_o(fpu_o), .fpu_done(fpu_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural FPU: restarts its latency count whenever {a,b} changes.
  logic [2*VW-1:0] last_ab = '0;
  int              lat = 0;
  int              lat_cnt = 0;
  logic            hold_low = 1'b0;

  always @(posedge clk) begin
    if ({fpu_a, fpu_b} != last_ab) begin
      last_ab <= {fpu_a, fpu_b};
      lat_cnt <= lat;
    end else if (lat_cnt != 0) begin
      lat_cnt <= lat_cnt - 1;
    end
  end

  assign fpu_done = !hold_low && (lat_cnt == 0) && ({fpu_a, fpu_b} == last_ab);
  assign fpu_o    = fpu_p[0] ? (fpu_a + fpu_b) : fpu_t;

  // Observers: kick-pattern hits on fpu_a and cycles with wb_valid high.
  logic [VW-1:0] kick_pat = '1;
  int            kick_hits = 0;
  int            wb_hits = 0;

  always @(posedge clk) begin
    if (fpu_a == kick_pat) kick_hits <= kick_hits + 1;
    if (bus_if.wb_valid)   wb_hits   <= wb_hits + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [63:0] a, input logic [63:0] b, input logic [63:0] t,
                      input logic [63:0] p, input logic [5:0] tag);
    bus_if.req_ir    = 41'h155;
    bus_if.req_rm    = 3'd1;
    bus_if.req_a     = a;
    bus_if.req_b     = b;
    bus_if.req_c     = '0;
    bus_if.req_t     = t;
    bus_if.req_p     = p;
    bus_if.req_tag   = tag;
    bus_if.req_valid = 1'b1;
    check_val("req_ready_at_push", {63'd0, bus_if.req_ready}, 64'd1);
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
  endtask

  task automatic wait_wb(input int budget, output int n);
    n = 0;
    while (!bus_if.wb_valid && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("wb_valid_within_budget", {63'd0, bus_if.wb_valid}, 64'd1);
  endtask

  task automatic take_wb();
    bus_if.wb_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.wb_ready = 1'b0;
  endtask

  initial begin
    int n;
    int k0;
    int w0;
    bus_if.req_valid = 1'b0;
    bus_if.req_ir    = '0;
    bus_if.req_rm    = '0;
    bus_if.req_a     = '0;
    bus_if.req_b     = '0;
    bus_if.req_c     = '0;
    bus_if.req_t     = '0;
    bus_if.req_p     = '0;
    bus_if.req_tag   = '0;
    bus_if.wb_ready  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_wb_valid", {63'd0, bus_if.wb_valid}, 64'd0);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_req_ready", {63'd0, bus_if.req_ready}, 64'd0);
    check_val("rst_wb_res", bus_if.wb_res, 64'd0);
    check_val("rst_fpu_p", fpu_p, 64'd0);
    rst_n = 1'b1;
    #1;
    check_val("rel_req_ready", {63'd0, bus_if.req_ready}, 64'd1);
    @(posedge clk); #1;

    // 1: single op, immediate done
    lat = 0;
    push(64'd1, 64'd2, 64'd0, 64'd1, 6'd5);
    wait_wb(40, n);
    check_val("t1_latency", 64'(n), 64'd6);
    check_val("t1_res", bus_if.wb_res, 64'd3);
    check_val("t1_tag", 64'(bus_if.wb_tag), 64'd5);
    check_val("t1_err", {63'd0, bus_if.wb_err}, 64'd0);
    take_wb();
    check_val("t1_idle_busy", {63'd0, busy}, 64'd0);
    check_val("t1_idle_fpu_p", fpu_p, 64'd0);

    // 2: identical operands back to back still restart the FPU
    lat = 8;
    push(64'd7, 64'd7, 64'd0, 64'd1, 6'd1);
    push(64'd7, 64'd7, 64'd0, 64'd1, 6'd2);
    wait_wb(60, n);
    check_val("t2_lat_a", 64'(n), 64'd11);
    check_val("t2_res_a", bus_if.wb_res, 64'd14);
    check_val("t2_tag_a", 64'(bus_if.wb_tag), 64'd1);
    take_wb();
    wait_wb(60, n);
    check_val("t2_lat_b", 64'(n), 64'd11);
    check_val("t2_res_b", bus_if.wb_res, 64'd14);
    check_val("t2_tag_b", 64'(bus_if.wb_tag), 64'd2);
    take_wb();

    // 3: predicate false passes t straight through without a kick
    lat = 0;
    kick_pat = ~64'h1234;
    @(posedge clk); #1;
    k0 = kick_hits;
    push(64'h1234, 64'h55, 64'hABCD, 64'd0, 6'd3);
    wait_wb(20, n);
    check_val("t3_latency", 64'(n), 64'd1);
    check_val("t3_res", bus_if.wb_res, 64'hABCD);
    check_val("t3_tag", 64'(bus_if.wb_tag), 64'd3);
    check_val("t3_err", {63'd0, bus_if.wb_err}, 64'd0);
    check_val("t3_no_kick", 64'(kick_hits - k0), 64'd0);
    take_wb();

    // 4: fill FIFO plus one in flight with writeback stalled
    for (int i = 0; i < 5; i++) push(64'(10 + i), 64'd100, 64'd0, 64'd1, 6'(20 + i));
    check_val("t4_full_ready", {63'd0, bus_if.req_ready}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      wait_wb(60, n);
      check_val("t4_tag", 64'(bus_if.wb_tag), 64'(20 + i));
      check_val("t4_res", bus_if.wb_res, 64'(110 + i));
      take_wb();
    end
    check_val("t4_drained_busy", {63'd0, busy}, 64'd0);

    // 5: done stuck low times out, next op recovers
    hold_low = 1'b1;
    push(64'd3, 64'd4, 64'd0, 64'd1, 6'd9);
    wait_wb(400, n);
    check_val("t5_tmo_latency", 64'(n), 64'd260);
    check_val("t5_err", {63'd0, bus_if.wb_err}, 64'd1);
    check_val("t5_res", bus_if.wb_res, 64'd0);
    check_val("t5_tag", 64'(bus_if.wb_tag), 64'd9);
    hold_low = 1'b0;
    take_wb();
    push(64'd10, 64'd20, 64'd0, 64'd1, 6'd10);
    wait_wb(40, n);
    check_val("t5_next_latency", 64'(n), 64'd6);
    check_val("t5_next_res", bus_if.wb_res, 64'd30);
    check_val("t5_next_err", {63'd0, bus_if.wb_err}, 64'd0);
    take_wb();

    // 6a: flush during WAIT with three queued, concurrent push dropped
    lat = 20;
    for (int i = 0; i < 4; i++) push(64'd1, 64'd1, 64'd0, 64'd1, 6'(30 + i));
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    bus_if.req_tag   = 6'd40;
    bus_if.req_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus_if.req_valid = 1'b0;
    w0 = wb_hits;
    check_val("t6_flush_wb_valid", {63'd0, bus_if.wb_valid}, 64'd0);
    check_val("t6_flush_busy", {63'd0, busy}, 64'd0);
    check_val("t6_flush_req_ready", {63'd0, bus_if.req_ready}, 64'd1);
    repeat (30) @(posedge clk);
    #1;
    check_val("t6_flush_no_stale_wb", 64'(wb_hits - w0), 64'd0);
    check_val("t6_flush_still_idle", {63'd0, busy}, 64'd0);

    // 6b: asynchronous reset mid-LOAD
    lat = 0;
    push(64'd5, 64'd6, 64'd0, 64'd1, 6'd11);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_wb_valid", {63'd0, bus_if.wb_valid}, 64'd0);
    check_val("t6_rst_busy", {63'd0, busy}, 64'd0);
    check_val("t6_rst_fpu_a", fpu_a, 64'd0);
    rst_n = 1'b1;
    #1;
    check_val("t6_rst_req_ready", {63'd0, bus_if.req_ready}, 64'd1);
    w0 = wb_hits;
    repeat (30) @(posedge clk);
    #1;
    check_val("t6_rst_no_stale_wb", 64'(wb_hits - w0), 64'd0);
    check_val("t6_rst_idle", {63'd0, busy}, 64'd0);
    push(64'd2, 64'd2, 64'd0, 64'd1, 6'd12);
    wait_wb(40, n);
    check_val("t6_after_latency", 64'(n), 64'd6);
    check_val("t6_after_res", bus_if.wb_res, 64'd4);
    check_val("t6_after_tag", 64'(bus_if.wb_tag), 64'd12);
    take_wb();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
